ysyx_22041412_div_radix2: RTL and testbench

Parametrised iterative radix-2 restoring divider with a full valid/ready handshake on both sides, for the EX-stage M-extension path. It produces one quotient bit per cycle. Word-mode operations finish early, after half the iterations. It implements RISC-V divide-by-zero and signed-overflow results. It supports flush and output backpressure. It is the next-generation divider under the ALU: the ALU drives `in_valid` from its div enable and takes `out_valid`/`result` as its ready/result pair.

---
 rtl/ysyx_22041412_div_pkg.sv | 15 +
 rtl/ysyx_22041412_div_step.sv | 17 +
 rtl/ysyx_22041412_div_radix2.sv | 118 +++++++++++
 tb/tb_ysyx_22041412_div_radix2.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_div_pkg.sv
// ysyx_22041412_div_pkg: shared state encoding, counter sizing and special-case constants for the radix-2 divider
package ysyx_22041412_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int MAXW = 128;
  function automatic int cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction
  function automatic logic [MAXW-1:0] all_ones(input int w);
    return (MAXW'(1) << w) - MAXW'(1);
  endfunction
  // Most-negative value of width w, already sign-extended so any truncation stays correct
  function automatic logic [MAXW-1:0] min_neg(input int w);
    return ~all_ones(w - 1);
  endfunction
endpackage

// File: rtl/ysyx_22041412_div_step.sv
// ysyx_22041412_div_step: one combinational restoring iteration (shift, trial subtract, restore on borrow)
module ysyx_22041412_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;
  assign sh = {rem, quo[XLEN-1]};
  assign diff = sh - {1'b0, divisor};
  assign rem_next = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/ysyx_22041412_div_radix2.sv
// ysyx_22041412_div_radix2: iterative radix-2 restoring divider with valid/ready handshakes.
// Define YSYX_22041412_DIV_FASTZERO_EN to finish divide-by-zero and signed overflow straight from accept.
module ysyx_22041412_div_radix2
  import ysyx_22041412_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic            op_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int HALF = XLEN / 2;
  localparam int CW = cnt_w(XLEN);
  localparam logic [XLEN-1:0] ONES = XLEN'(all_ones(XLEN));
  localparam logic [XLEN-1:0] MIN_D = XLEN'(min_neg(XLEN));
  localparam logic [XLEN-1:0] MIN_W = XLEN'(min_neg(HALF));
  state_t state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] rem, quo, dvs;
  logic q_neg, r_neg, rem_sel, word, dz, ov;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, rem_n, quo_n, q_fix, r_fix, sel, fix_res;
  logic sa, sb, dz_in, ov_in;
  assign in_ready = (state == IDLE);
  assign busy = !in_ready;
  assign ext_a = op_word ? {{HALF{op_signed & dividend[HALF-1]}}, dividend[HALF-1:0]} : dividend;
  assign ext_b = op_word ? {{HALF{op_signed & divisor[HALF-1]}}, divisor[HALF-1:0]} : divisor;
  assign sa = op_signed & ext_a[XLEN-1];
  assign sb = op_signed & ext_b[XLEN-1];
  assign mag_a = sa ? -ext_a : ext_a;
  assign mag_b = sb ? -ext_b : ext_b;
  assign dz_in = (ext_b == '0);
  assign ov_in = op_signed & (ext_b == ONES) & (ext_a == (op_word ? MIN_W : MIN_D));
  // A zero divisor yields the magnitude as remainder, so only the quotient needs forcing
  assign q_fix = q_neg ? -quo : quo;
  assign r_fix = r_neg ? -rem : rem;
  assign sel = rem_sel ? (ov ? '0 : r_fix) : (dz ? ONES : q_fix);
  assign fix_res = word ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
`ifdef YSYX_22041412_DIV_FASTZERO_EN
  logic [XLEN-1:0] spec_res;
  assign spec_res = op_rem ? (dz_in ? ext_a : '0) : (dz_in ? ONES : ext_a);
`endif
  ysyx_22041412_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_next(rem_n),
    .quo_next(quo_n)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rem_sel <= 1'b0;
      word <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rem <= '0;
          quo <= op_word ? mag_a << HALF : mag_a;
          dvs <= mag_b;
          q_neg <= sa ^ sb;
          r_neg <= sa;
          rem_sel <= op_rem;
          word <= op_word;
          dz <= dz_in;
          ov <= ov_in;
          cnt <= CW'(op_word ? HALF : XLEN);
`ifdef YSYX_22041412_DIV_FASTZERO_EN
          state <= (dz_in | ov_in) ? DONE : CALC;
          out_valid <= dz_in | ov_in;
          if (dz_in | ov_in) result <= spec_res;
`else
          state <= CALC;
`endif
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22041412_div_radix2.sv
// tb_ysyx_22041412_div_radix2: directed vector table plus backpressure, flush and reset sequences
module tb_ysyx_22041412_div_radix2;
`ifdef YSYX_22041412_DIV_FASTZERO_EN
  localparam int ZL = 1;
  localparam int ZLW = 1;
`else
  localparam int ZL = 66;
  localparam int ZLW = 34;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 0, rst = 0, in_valid = 0, op_signed = 0, op_rem = 0, op_word = 0, flush = 0, out_ready = 0;
  logic [63:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, busy;
  logic [63:0] result;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic s;
    logic r;
    logic w;
    logic [63:0] exp;
    int lat;
  } vec_t;
  vec_t v[20];
  ysyx_22041412_div_radix2 #(.XLEN(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .op_signed(op_signed),
    .op_rem   (op_rem),
    .op_word  (op_word),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic r, input logic w);
    @(negedge clk);
    dividend = a;
    divisor = b;
    op_signed = s;
    op_rem = r;
    op_word = w;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_valid(output int lat, output int rdy_err);
    lat = 1;
    rdy_err = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready || !busy) rdy_err++;
      @(posedge clk);
      #1 lat++;
    end
    if (in_ready || !busy) rdy_err++;
  endtask
  task automatic take();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  initial begin
    int lat, err;
    logic ok, seen;
    v[0]  = '{64'd100, 64'd7, 0, 0, 0, 64'd14, 66};
    v[1]  = '{64'd100, 64'd7, 0, 1, 0, 64'd2, 66};
    v[2]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    v[3]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 1, 0, ONES, 66};
    v[4]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    v[5]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0, 64'd1, 66};
    v[6]  = '{64'd5, 64'd0, 0, 0, 0, ONES, ZL};
    v[7]  = '{64'd5, 64'd0, 0, 1, 0, 64'd5, ZL};
    v[8]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1, 0, 0, ONES, ZL};
    v[9]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFB, ZL};
    v[10] = '{64'h8000_0000_0000_0000, ONES, 1, 0, 0, 64'h8000_0000_0000_0000, ZL};
    v[11] = '{64'h8000_0000_0000_0000, ONES, 1, 1, 0, 64'd0, ZL};
    v[12] = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, ZLW};
    v[13] = '{64'hDEAD_BEEF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001, 0, 0, 1, ONES, 34};
    v[14] = '{64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, 34};
    v[15] = '{64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 1, 1, 1, ONES, 34};
    v[16] = '{ONES, 64'h8000_0000_0000_0000, 0, 0, 0, 64'd1, 66};
    v[17] = '{ONES, 64'h8000_0000_0000_0000, 0, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 66};
    v[18] = '{64'h0000_0000_8000_0000, 64'd3, 0, 0, 1, 64'h0000_0000_2AAA_AAAA, 34};
    v[19] = '{64'h0000_0000_8000_0000, 64'd3, 0, 1, 1, 64'd2, 34};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1;
    for (int i = 0; i < 20; i++) begin
      start_op(v[i].a, v[i].b, v[i].s, v[i].r, v[i].w);
      wait_valid(lat, err);
      chk($sformatf("vec%0d_result", i), result, v[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(v[i].lat));
      chk($sformatf("vec%0d_in_ready_low", i), 64'(err), 64'd0);
      take();
    end
    start_op(64'd100, 64'd7, 0, 0, 0);
    wait_valid(lat, err);
    ok = 1;
    repeat (10) begin
      @(posedge clk);
      #1 if (!out_valid || result !== 64'd14) ok = 0;
    end
    chk("backpressure_stable", 64'(ok), 64'd1);
    take();
    chk("handshake_idle", 64'({in_ready, out_valid}), 64'b10);
    start_op(64'd1000, 64'd9, 0, 0, 0);
    repeat (19) @(posedge clk);
    @(negedge clk) flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("flush_idle", 64'({in_ready, busy}), 64'b10);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    @(negedge clk);
    dividend = 64'd50;
    divisor = 64'd5;
    in_valid = 1;
    flush = 1;
    @(posedge clk);
    #1 in_valid = 0;
    flush = 0;
    chk("flush_blocks_accept", 64'(busy), 64'd0);
    start_op(64'd100, 64'd7, 0, 0, 0);
    wait_valid(lat, err);
    chk("post_flush_result", result, 64'd14);
    take();
    start_op(64'd100, 64'd7, 0, 1, 0);
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 0;
    #1;
    chk("async_reset_outputs", 64'({out_valid, in_ready, busy}), 64'b010);
    chk("async_reset_result", result, 64'd0);
    @(negedge clk) rst = 1;
    start_op(64'd100, 64'd7, 0, 1, 0);
    wait_valid(lat, err);
    chk("post_reset_result", result, 64'd2);
    chk("post_reset_latency", 64'(lat), 64'd66);
    take();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
